rv_alu: RTL and testbench
=========================

Name: rv_alu

Overview:
- RV32I integer ALU for the execute stage of the core.
- Takes two register operands plus the funct3/funct7 decode bits.
- Produces a registered result and a registered zero flag one clock after the operands are presented.
- Purely data-path: no handshake; a new operation is accepted every cycle.

Parameters:
- XLEN, 32, operand/result width in bits; must be a power of two ≥ 8.
- SHAMT_W, $clog2(XLEN) (5 at default), number of low rs2 bits used as shift amount; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- rs1  input  XLEN  operand A.
- rs2  input  XLEN  operand B.
- funct3  input  3  operation select (RV32I OP encoding).
- funct7  input  1  instruction bit 30; selects SUB/SRA variants.
- rd  output  XLEN  registered result.
- z  output  1  registered zero flag; 1 when the registered rd is all zeros.

Interface decision: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset (rst=1, asynchronous assert): rd=0 and z=1 immediately. Outputs hold while rst is high.
- Release of rst is synchronous to clk.
- Latency: exactly 1 cycle. Inputs sampled at rising edge N drive rd/z from edge N until edge N+1.
- Throughput: one operation per cycle. No stall or enable; inputs must be valid every cycle.
- Operation map (funct3, funct7):
  - 000,0 ADD: rs1+rs2, modulo 2^XLEN, carry discarded.
  - 000,1 SUB: rs1-rs2, modulo 2^XLEN.
  - 001,x SLL: rs1 << rs2[SHAMT_W-1:0].
  - 010,x SLT: signed rs1<rs2 gives 1, else 0; result zero-extended.
  - 011,x SLTU: unsigned compare, same result format as SLT.
  - 100,x XOR: rs1^rs2.
  - 101,0 SRL: logical right shift by rs2[SHAMT_W-1:0].
  - 101,1 SRA: arithmetic right shift by rs2[SHAMT_W-1:0], sign-filled from rs1[XLEN-1].
  - 110,x OR: rs1|rs2.
  - 111,x AND: rs1&rs2.
- funct7 is ignored for every funct3 other than 000 and 101.
- Upper bits of rs2 above SHAMT_W are ignored for shifts, so a shift amount of 32 shifts by 0.
- Shift by 0 returns rs1 unchanged.
- z is computed from the next-state result in the same edge as rd, so z always equals (rd==0) and never lags rd.
- Overflow on ADD/SUB wraps silently; no exception.
- No X-propagation masking is required. With all inputs known, rd and z are never X.

Optional Feature:
- Macro ALU_FLAGS_EN.
- When defined, three extra registered outputs are added, updated on the same edge as rd and cleared to 0 on reset:
  - n (1 bit) = rd[XLEN-1].
  - c (1 bit) = carry-out of ADD, or NOT borrow of SUB; 0 for all other operations.
  - v (1 bit) = signed overflow of ADD/SUB; 0 for all other operations.
- When not defined, these ports and their logic do not exist. Core behaviour is unchanged in both cases.

Test Plan:
- Reset: assert rst mid-operation with rd=0x32 → rd=0 and z=1 without waiting for a clk edge; after release, the first edge loads the new result.
- ADD/SUB: rs1=20, rs2=30, funct3=000, funct7=0 → rd=50 next cycle. funct7=1 → rd=0xFFFFFFF6, z=0. rs1=rs2=20, SUB → rd=0, z=1.
- Shifts: rs1=8, rs2=3: SLL → 64; SRL → 1. rs1=0x80000000, rs2=4: SRA → 0xF8000000, SRL → 0x08000000. rs2=0x23 with SLL → shift by 3.
- Compares: rs1=8, rs2=3: SLT → 0, SLTU → 0. rs1=0xFFFFFFFF, rs2=1: SLT → 1, SLTU → 0.
- Logic: rs1=20, rs2=30: OR → 30, AND → 20, XOR → 10. rs1=rs2 with XOR → rd=0, z=1. funct7=1 must not alter any of these results.
- Back-to-back: change the operation every cycle across all 10 ops → each result appears exactly one cycle later with no bubbles. If ALU_FLAGS_EN is defined, 0x7FFFFFFF+1 → v=1, n=1, c=0.

Source files
------------

// File: rtl/rv_alu.sv
// rtl/rv_alu.sv - RV32I execute-stage ALU with registered result and zero flag.
// Optional n/c/v flag outputs are built when ALU_FLAGS_EN is defined.
module rv_alu #(
   parameter  int XLEN    = 32,
   localparam int SHAMT_W = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic [2:0]      funct3,
   input  logic            funct7,
   output logic [XLEN-1:0] rd,
   output logic            z
`ifdef ALU_FLAGS_EN
   ,
   output logic            n,
   output logic            c,
   output logic            v
`endif
);

   logic [XLEN-1:0]    rd_d, rd_q;
   logic               z_d, z_q;
   logic [SHAMT_W-1:0] shamt;
   logic [XLEN-1:0]    addsub;
   logic               is_sub;

`ifdef ALU_FLAGS_EN
   logic        n_d, n_q, c_d, c_q, v_d, v_q;
   logic [XLEN:0] addsub_x;
   logic        ovf;
`endif

   always_comb begin
      shamt  = rs2[SHAMT_W-1:0];
      is_sub = funct7;
`ifdef ALU_FLAGS_EN
      // SUB as rs1 + ~rs2 + 1 makes the carry-out equal to NOT borrow.
      addsub_x = {1'b0, rs1} + {1'b0, (is_sub ? ~rs2 : rs2)} + {{XLEN{1'b0}}, is_sub};
      addsub   = addsub_x[XLEN-1:0];
      ovf      = is_sub ? ((rs1[XLEN-1] != rs2[XLEN-1]) && (addsub[XLEN-1] != rs1[XLEN-1]))
                        : ((rs1[XLEN-1] == rs2[XLEN-1]) && (addsub[XLEN-1] != rs1[XLEN-1]));
`else
      addsub = rs1 + (is_sub ? ~rs2 : rs2) + {{(XLEN-1){1'b0}}, is_sub};
`endif

      rd_d = '0;
      unique case (funct3)
         3'b000: rd_d = addsub;
         3'b001: rd_d = rs1 << shamt;
         3'b010: rd_d = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
         3'b011: rd_d = {{(XLEN-1){1'b0}}, (rs1 < rs2)};
         3'b100: rd_d = rs1 ^ rs2;
         3'b101: rd_d = funct7 ? $unsigned($signed(rs1) >>> shamt) : (rs1 >> shamt);
         3'b110: rd_d = rs1 | rs2;
         3'b111: rd_d = rs1 & rs2;
         default: rd_d = '0;
      endcase

      // Zero flag is derived from the next result so it never lags rd.
      z_d = (rd_d == '0);

`ifdef ALU_FLAGS_EN
      n_d = rd_d[XLEN-1];
      c_d = (funct3 == 3'b000) ? addsub_x[XLEN] : 1'b0;
      v_d = (funct3 == 3'b000) ? ovf : 1'b0;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q <= '0;
         z_q  <= 1'b1;
      end else begin
         rd_q <= rd_d;
         z_q  <= z_d;
      end
   end

`ifdef ALU_FLAGS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n_q <= 1'b0;
         c_q <= 1'b0;
         v_q <= 1'b0;
      end else begin
         n_q <= n_d;
         c_q <= c_d;
         v_q <= v_d;
      end
   end

   assign n = n_q;
   assign c = c_q;
   assign v = v_q;
`endif

   assign rd = rd_q;
   assign z  = z_q;

endmodule

// File: tb/tb_rv_alu.sv
// tb/tb_rv_alu.sv - self-checking bench for rv_alu against an arithmetic reference model.
// Flag outputs are checked when ALU_FLAGS_EN is defined.
module tb_rv_alu;

   logic        clk;
   logic        rst;
   logic [31:0] rs1, rs2;
   logic [2:0]  funct3;
   logic        funct7;
   logic [31:0] rd;
   logic        z;
`ifdef ALU_FLAGS_EN
   logic        n, c, v;
`endif

   int errors = 0;
   int checks = 0;

   rv_alu #(.XLEN(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .rs1    (rs1),
      .rs2    (rs2),
      .funct3 (funct3),
      .funct7 (funct7),
      .rd     (rd),
      .z      (z)
`ifdef ALU_FLAGS_EN
      ,
      .n      (n),
      .c      (c),
      .v      (v)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ref_rd(input logic [2:0] f3, input logic f7,
                                          input logic [31:0] a, input logic [31:0] b);
      int unsigned sh;
      longint      sa, sb, ua, ub;
      sh = b % 32;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'(a);
      ub = longint'(b);
      case (f3)
         3'd0: return f7 ? 32'(ua - ub) : 32'(ua + ub);
         3'd1: return 32'(ua * (longint'(1) << sh));
         3'd2: return (sa < sb) ? 32'd1 : 32'd0;
         3'd3: return (ua < ub) ? 32'd1 : 32'd0;
         3'd4: return a ^ b;
         3'd5: return f7 ? 32'(sa >>> sh) : 32'(ua / (longint'(1) << sh));
         3'd6: return a | b;
         default: return a & b;
      endcase
   endfunction

   function automatic logic [2:0] ref_ncv(input logic [2:0] f3, input logic f7,
                                          input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub, s;
      logic   cc, vv;
      logic [31:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'(a);
      ub = longint'(b);
      r  = ref_rd(f3, f7, a, b);
      cc = 1'b0;
      vv = 1'b0;
      if (f3 == 3'd0) begin
         if (f7) begin
            cc = (ua >= ub);
            s  = sa - sb;
         end else begin
            cc = (ua + ub) > 64'hFFFF_FFFF;
            s  = sa + sb;
         end
         vv = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      return {r[31], cc, vv};
   endfunction

   task automatic drive(input logic [2:0] f3, input logic f7,
                        input logic [31:0] a, input logic [31:0] b);
      funct3 = f3;
      funct7 = f7;
      rs1    = a;
      rs2    = b;
   endtask

   // Apply one op and sample one time step after the loading edge.
   task automatic apply(input logic [2:0] f3, input logic f7,
                        input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      drive(f3, f7, a, b);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      drive(3'd0, 1'b0, 32'd0, 32'd0);
      #1;
      checks++;
      if (rd !== 32'd0 || z !== 1'b1) begin
         errors++;
         $display("FAIL reset_initial rd=%h z=%b expected rd=0 z=1", rd, z);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      apply(3'd0, 1'b0, 32'h20, 32'h12);
      checks++;
      if (rd !== 32'h32 || z !== 1'b0) begin
         errors++;
         $display("FAIL reset_preload rd=%h z=%b expected rd=32 z=0", rd, z);
      end
      @(negedge clk);
      drive(3'd0, 1'b0, 32'd20, 32'd30);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (rd !== 32'd0 || z !== 1'b1) begin
         errors++;
         $display("FAIL reset_async rd=%h z=%b expected rd=0 z=1", rd, z);
      end
`ifdef ALU_FLAGS_EN
      checks++;
      if ({n, c, v} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags ncv=%b expected 000", {n, c, v});
      end
`endif
      @(posedge clk);
      #1;
      checks++;
      if (rd !== 32'd0) begin
         errors++;
         $display("FAIL reset_hold rd=%h expected 0", rd);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (rd !== 32'd50 || z !== 1'b0) begin
         errors++;
         $display("FAIL reset_release rd=%h z=%b expected rd=32 (50) z=0", rd, z);
      end
   endtask

   task automatic test_addsub;
      apply(3'd0, 1'b0, 32'd20, 32'd30);
      checks++;
      if (rd !== 32'd50 || z !== 1'b0) begin
         errors++;
         $display("FAIL add rd=%h z=%b expected 00000032 0", rd, z);
      end
      apply(3'd0, 1'b1, 32'd20, 32'd30);
      checks++;
      if (rd !== 32'hFFFF_FFF6 || z !== 1'b0) begin
         errors++;
         $display("FAIL sub_neg rd=%h z=%b expected fffffff6 0", rd, z);
      end
      apply(3'd0, 1'b1, 32'd20, 32'd20);
      checks++;
      if (rd !== 32'd0 || z !== 1'b1) begin
         errors++;
         $display("FAIL sub_zero rd=%h z=%b expected 0 1", rd, z);
      end
      apply(3'd0, 1'b0, 32'hFFFF_FFFF, 32'd1);
      checks++;
      if (rd !== 32'd0 || z !== 1'b1) begin
         errors++;
         $display("FAIL add_wrap rd=%h z=%b expected 0 1", rd, z);
      end
`ifdef ALU_FLAGS_EN
      checks++;
      if ({n, c, v} !== 3'b010) begin
         errors++;
         $display("FAIL add_wrap_flags ncv=%b expected 010", {n, c, v});
      end
`endif
   endtask

   task automatic test_shifts;
      logic [2:0] f3s [6] = '{3'd1, 3'd5, 3'd5, 3'd5, 3'd1, 3'd5};
      logic       f7s [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [31:0] as [6] = '{32'd8, 32'd8, 32'h8000_0000, 32'h8000_0000, 32'd8, 32'h8000_0000};
      logic [31:0] bs [6] = '{32'd3, 32'd3, 32'd4, 32'd4, 32'h23, 32'd32};
      logic [31:0] ex [6] = '{32'd64, 32'd1, 32'hF800_0000, 32'h0800_0000, 32'd64, 32'h8000_0000};
      for (int i = 0; i < 6; i++) begin
         apply(f3s[i], f7s[i], as[i], bs[i]);
         checks++;
         if (rd !== ex[i]) begin
            errors++;
            $display("FAIL shift_%0d rd=%h expected %h", i, rd, ex[i]);
         end
      end
   endtask

   task automatic test_compares;
      logic [2:0] f3s [5] = '{3'd2, 3'd3, 3'd2, 3'd3, 3'd3};
      logic [31:0] as [5] = '{32'd8, 32'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1};
      logic [31:0] bs [5] = '{32'd3, 32'd3, 32'd1, 32'd1, 32'hFFFF_FFFF};
      logic [31:0] ex [5] = '{32'd0, 32'd0, 32'd1, 32'd0, 32'd1};
      for (int i = 0; i < 5; i++) begin
         apply(f3s[i], 1'b0, as[i], bs[i]);
         checks++;
         if (rd !== ex[i] || z !== (ex[i] == 32'd0)) begin
            errors++;
            $display("FAIL cmp_%0d rd=%h z=%b expected %h", i, rd, z, ex[i]);
         end
      end
   endtask

   task automatic test_logic;
      logic [2:0] f3s [3] = '{3'd6, 3'd7, 3'd4};
      logic [31:0] ex [3] = '{32'd30, 32'd20, 32'd10};
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 3; i++) begin
            apply(f3s[i], k[0], 32'd20, 32'd30);
            checks++;
            if (rd !== ex[i]) begin
               errors++;
               $display("FAIL logic_%0d_f7_%0d rd=%h expected %h", i, k, rd, ex[i]);
            end
         end
         apply(3'd4, k[0], 32'hA5A5_1234, 32'hA5A5_1234);
         checks++;
         if (rd !== 32'd0 || z !== 1'b1) begin
            errors++;
            $display("FAIL xor_self_f7_%0d rd=%h z=%b expected 0 1", k, rd, z);
         end
      end
   endtask

   // Ops change every cycle; each result must appear on the very next edge.
   task automatic test_back_to_back(input int count, input bit directed);
      logic [2:0]  f3_q [$];
      logic        f7_q [$];
      logic [31:0] a_q [$], b_q [$];
      logic [31:0] exp_rd;
      logic [2:0]  op3;
      logic        op7;
      logic [31:0] a, b;
      for (int i = 0; i < count; i++) begin
         if (directed) begin
            op3 = (i < 10) ? ((i < 2) ? 3'd0 : ((i < 7) ? 3'(i - 1) : ((i < 9) ? 3'd5 : 3'd7))) : 3'd0;
            op7 = (i == 1) || (i == 8);
            a   = 32'h8000_0010 + 32'(i);
            b   = 32'd3 + 32'(i);
            if (i == 7) op3 = 3'd6;
            if (i == 9) op3 = 3'd7;
         end else begin
            op3 = 3'($urandom_range(0, 7));
            op7 = 1'($urandom_range(0, 1));
            a   = $urandom;
            case ($urandom_range(0, 3))
               0: b = a;
               1: b = 32'($urandom_range(0, 40));
               default: b = $urandom;
            endcase
         end
         f3_q.push_back(op3);
         f7_q.push_back(op7);
         a_q.push_back(a);
         b_q.push_back(b);
      end
      @(negedge clk);
      drive(f3_q[0], f7_q[0], a_q[0], b_q[0]);
      for (int i = 0; i < count; i++) begin
         @(posedge clk);
         #1;
         exp_rd = ref_rd(f3_q[i], f7_q[i], a_q[i], b_q[i]);
         checks++;
         if (rd !== exp_rd || z !== (exp_rd == 32'd0)) begin
            errors++;
            $display("FAIL b2b_%0d op=%0d/%0d a=%h b=%h rd=%h z=%b expected %h",
                     i, f3_q[i], f7_q[i], a_q[i], b_q[i], rd, z, exp_rd);
         end
`ifdef ALU_FLAGS_EN
         checks++;
         if ({n, c, v} !== ref_ncv(f3_q[i], f7_q[i], a_q[i], b_q[i])) begin
            errors++;
            $display("FAIL b2b_flags_%0d ncv=%b expected %b", i, {n, c, v},
                     ref_ncv(f3_q[i], f7_q[i], a_q[i], b_q[i]));
         end
`endif
         if (i + 1 < count) drive(f3_q[i+1], f7_q[i+1], a_q[i+1], b_q[i+1]);
      end
   endtask

   task automatic test_flags;
`ifdef ALU_FLAGS_EN
      apply(3'd0, 1'b0, 32'h7FFF_FFFF, 32'd1);
      checks++;
      if (rd !== 32'h8000_0000 || {n, c, v} !== 3'b101) begin
         errors++;
         $display("FAIL flags_ovf rd=%h ncv=%b expected 80000000 101", rd, {n, c, v});
      end
      apply(3'd0, 1'b1, 32'd5, 32'd3);
      checks++;
      if ({n, c, v} !== 3'b010) begin
         errors++;
         $display("FAIL flags_sub_noborrow ncv=%b expected 010", {n, c, v});
      end
`endif
   endtask

   initial begin
      test_reset();
      test_addsub();
      test_shifts();
      test_compares();
      test_logic();
      test_back_to_back(10, 1'b1);
      test_back_to_back(300, 1'b0);
      test_flags();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
